microsequencer: RTL and testbench

- Parametrised next-state engine for the microprogrammed SPARC control unit. It replaces the fixed hard-coded state transitions of the current control unit.
- Each cycle it selects the next microstate from eight sources: increment, jump, opcode decode, conditional branch, memory wait, call, return and fetch.
- Its State output addresses the external control-word ROM, which drives the RF_Ld/MUX_*/OP signals.
- Adds a subroutine return stack, a memory-wait timeout and sticky error flags.

---
 rtl/microsequencer.sv | 175 +++++++++++++++++
 tb/tb_microsequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/microsequencer.sv
// Microprogram next-state engine: eight next-state sources, return stack, sticky errors.
// Optional memory-wait timeout (counter, trap and Timeout_Err) built only with MICROSEQ_TIMEOUT_EN.
module microsequencer #(
  parameter int STATE_W     = 6,
  parameter int STACK_DEPTH = 2,
  parameter int WAIT_LIMIT  = 15,
  parameter int RESET_ADDR  = 0,
  parameter int FETCH_ADDR  = 1,
  parameter int TRAP_ADDR   = 63,
  localparam int LVL_W      = $clog2(STACK_DEPTH + 1)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [2:0]         Next_Sel,
  input  logic [STATE_W-1:0] Jump_Addr,
  input  logic [STATE_W-1:0] Decode_Addr,
  input  logic               Cond,
  input  logic               Cond_Inv,
  input  logic               Memory_Operation_Complete,
  input  logic               Clear_Err,
  output logic [STATE_W-1:0] State,
  output logic               MOV,
  output logic               Stack_Err,
  output logic               Timeout_Err,
  output logic [LVL_W-1:0]   Stack_Level
);

  typedef enum logic [2:0] {
    SEL_INC    = 3'd0,
    SEL_JUMP   = 3'd1,
    SEL_DECODE = 3'd2,
    SEL_CJUMP  = 3'd3,
    SEL_WAIT   = 3'd4,
    SEL_CALL   = 3'd5,
    SEL_RET    = 3'd6,
    SEL_FETCH  = 3'd7
  } sel_e;

  localparam logic [STATE_W-1:0] RESET_A = STATE_W'(RESET_ADDR);
  localparam logic [STATE_W-1:0] FETCH_A = STATE_W'(FETCH_ADDR);
  localparam logic [STATE_W-1:0] TRAP_A  = STATE_W'(TRAP_ADDR);
  localparam logic [LVL_W-1:0]   FULL_L  = LVL_W'(STACK_DEPTH);

  if (STACK_DEPTH < 1 || WAIT_LIMIT < 1) begin : g_param_check
    $error("microsequencer: STACK_DEPTH and WAIT_LIMIT must be at least 1");
  end

  sel_e               sel;
  logic [STATE_W-1:0] state_q, state_d, state_inc;
  logic [LVL_W-1:0]   lvl_q, lvl_d;
  logic               stack_err_q, stack_err_d;
  logic [STATE_W-1:0] stack_q [STACK_DEPTH];
  logic [STATE_W-1:0] pop_val;
  logic               stack_full, stack_empty;
  logic               push;
  logic               stack_fault;
  logic               timeout_fault;

  assign sel = sel_e'(Next_Sel);

  // MOV is held low while reset is asserted so the memory side never sees a request.
  assign MOV         = Reset & (sel == SEL_WAIT);
  assign State       = state_q;
  assign Stack_Level = lvl_q;
  assign Stack_Err   = stack_err_q;

  always_comb begin
    state_inc   = state_q + STATE_W'(1);
    stack_full  = (lvl_q == FULL_L);
    stack_empty = (lvl_q == '0);
    pop_val     = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (lvl_q == LVL_W'(i + 1)) pop_val = stack_q[i];
    end
  end

`ifdef MICROSEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(WAIT_LIMIT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_LIMIT - 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_err_q, timeout_err_d;

  // Counter holds the number of waiting cycles already spent; the edge that would
  // make it WAIT_LIMIT traps instead.
  always_comb begin
    wait_cnt_d    = '0;
    timeout_fault = 1'b0;
    if (sel == SEL_WAIT && !Memory_Operation_Complete) begin
      if (wait_cnt_q == LAST_CNT) timeout_fault = 1'b1;
      else                        wait_cnt_d    = wait_cnt_q + CNT_W'(1);
    end
    timeout_err_d = (timeout_err_q & ~Clear_Err) | timeout_fault;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign Timeout_Err = timeout_err_q;
`else
  assign timeout_fault = 1'b0;
  assign Timeout_Err   = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    lvl_d       = lvl_q;
    push        = 1'b0;
    stack_fault = 1'b0;
    case (sel)
      SEL_INC:    state_d = state_inc;
      SEL_JUMP:   state_d = Jump_Addr;
      SEL_DECODE: state_d = Decode_Addr;
      SEL_CJUMP:  state_d = (Cond ^ Cond_Inv) ? Jump_Addr : state_inc;
      SEL_WAIT: begin
        if (Memory_Operation_Complete) state_d = state_inc;
        else if (timeout_fault)        state_d = TRAP_A;
      end
      SEL_CALL: begin
        if (stack_full) begin
          stack_fault = 1'b1;
          state_d     = TRAP_A;
        end else begin
          push    = 1'b1;
          state_d = Jump_Addr;
          lvl_d   = lvl_q + LVL_W'(1);
        end
      end
      SEL_RET: begin
        if (stack_empty) begin
          stack_fault = 1'b1;
          state_d     = TRAP_A;
        end else begin
          state_d = pop_val;
          lvl_d   = lvl_q - LVL_W'(1);
        end
      end
      SEL_FETCH:  state_d = FETCH_A;
      default:    state_d = state_q;
    endcase
    // A new error outranks a simultaneous clear.
    stack_err_d = (stack_err_q & ~Clear_Err) | stack_fault;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= RESET_A;
      lvl_q       <= '0;
      stack_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lvl_q       <= lvl_d;
      stack_err_q <= stack_err_d;
    end
  end

  // Return addresses live at the index equal to the occupancy before the push.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (push && lvl_q == LVL_W'(i)) stack_q[i] <= state_inc;
      end
    end
  end

endmodule

// File: tb/tb_microsequencer.sv
// Randomized scoreboard bench for microsequencer against a queue-based reference model.
// Timeout expectations follow MICROSEQ_TIMEOUT_EN as seen by the bench build.
module tb_microsequencer;

  localparam int STATE_W     = 6;
  localparam int STACK_DEPTH = 2;
  localparam int WAIT_LIMIT  = 15;
  localparam int RESET_ADDR  = 0;
  localparam int FETCH_ADDR  = 1;
  localparam int TRAP_ADDR   = 63;
  localparam int LVL_W       = $clog2(STACK_DEPTH + 1);
  localparam int NSTATES     = 1 << STATE_W;

  logic               Clk;
  logic               Reset;
  logic [2:0]         Next_Sel;
  logic [STATE_W-1:0] Jump_Addr;
  logic [STATE_W-1:0] Decode_Addr;
  logic               Cond;
  logic               Cond_Inv;
  logic               Memory_Operation_Complete;
  logic               Clear_Err;
  logic [STATE_W-1:0] State;
  logic               MOV;
  logic               Stack_Err;
  logic               Timeout_Err;
  logic [LVL_W-1:0]   Stack_Level;

  microsequencer #(
    .STATE_W(STATE_W), .STACK_DEPTH(STACK_DEPTH), .WAIT_LIMIT(WAIT_LIMIT),
    .RESET_ADDR(RESET_ADDR), .FETCH_ADDR(FETCH_ADDR), .TRAP_ADDR(TRAP_ADDR)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Next_Sel(Next_Sel), .Jump_Addr(Jump_Addr),
    .Decode_Addr(Decode_Addr), .Cond(Cond), .Cond_Inv(Cond_Inv),
    .Memory_Operation_Complete(Memory_Operation_Complete), .Clear_Err(Clear_Err),
    .State(State), .MOV(MOV), .Stack_Err(Stack_Err), .Timeout_Err(Timeout_Err),
    .Stack_Level(Stack_Level)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    int st;
    int lvl;
    bit serr;
    bit terr;
    bit mov;
    bit rst;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  // Reference model: architectural state after the most recently driven edge.
  int   m_state = RESET_ADDR;
  int   m_stack[$];
  int   m_cnt = 0;
  bit   m_serr = 0;
  bit   m_terr = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic step(input int sel, input int ja, input int da, input bit c,
                      input bit ci, input bit moc, input bit clr, input bit rst_n);
    exp_t e;
    int   nxt;
    bit   serr_new;
    bit   terr_new;
    @(negedge Clk);
    Reset                     = rst_n;
    Next_Sel                  = 3'(sel);
    Jump_Addr                 = STATE_W'(ja);
    Decode_Addr               = STATE_W'(da);
    Cond                      = c;
    Cond_Inv                  = ci;
    Memory_Operation_Complete = moc;
    Clear_Err                 = clr;
    serr_new = 1'b0;
    terr_new = 1'b0;
    if (!rst_n) begin
      m_state = RESET_ADDR;
      m_stack.delete();
      m_cnt  = 0;
      m_serr = 1'b0;
      m_terr = 1'b0;
    end else begin
      nxt = (m_state + 1) % NSTATES;
      if (sel != 4) m_cnt = 0;
      case (sel)
        0: m_state = nxt;
        1: m_state = ja;
        2: m_state = da;
        3: m_state = (c != ci) ? ja : nxt;
        4: begin
          if (moc) begin
            m_state = nxt;
            m_cnt   = 0;
          end else begin
            m_cnt++;
`ifdef MICROSEQ_TIMEOUT_EN
            if (m_cnt >= WAIT_LIMIT) begin
              m_state  = TRAP_ADDR;
              terr_new = 1'b1;
              m_cnt    = 0;
            end
`endif
          end
        end
        5: begin
          if (m_stack.size() >= STACK_DEPTH) begin
            m_state  = TRAP_ADDR;
            serr_new = 1'b1;
          end else begin
            m_stack.push_back(nxt);
            m_state = ja;
          end
        end
        6: begin
          if (m_stack.size() == 0) begin
            m_state  = TRAP_ADDR;
            serr_new = 1'b1;
          end else begin
            m_state = m_stack.pop_back();
          end
        end
        default: m_state = FETCH_ADDR;
      endcase
      m_serr = (m_serr && !clr) || serr_new;
      m_terr = (m_terr && !clr) || terr_new;
    end
    e.st   = m_state;
    e.lvl  = m_stack.size();
    e.serr = m_serr;
    e.terr = m_terr;
    e.mov  = rst_n && (sel == 4);
    e.rst  = !rst_n;
    sb.push_back(e);
  endtask

  // Monitor: MOV mid-cycle against the pending entry, registered outputs after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      #2;
      if (sb.size() > 0) begin
        e = sb[0];
        chk("mov", int'(MOV), int'(e.mov));
        if (e.rst) begin
          chk("async_rst_state", int'(State), RESET_ADDR);
          chk("async_rst_level", int'(Stack_Level), 0);
        end
      end
      @(posedge Clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("state", int'(State), e.st);
        chk("stack_level", int'(Stack_Level), e.lvl);
        chk("stack_err", int'(Stack_Err), int'(e.serr));
        chk("timeout_err", int'(Timeout_Err), int'(e.terr));
      end
    end
  end

  initial begin
    Reset = 1'b0; Next_Sel = 3'd0; Jump_Addr = '0; Decode_Addr = '0;
    Cond = 1'b0; Cond_Inv = 1'b0; Memory_Operation_Complete = 1'b0; Clear_Err = 1'b0;

    // Reset, increment and wrap
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 63, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(2, 0, 44, 0, 0, 0, 0, 1);
    step(7, 0, 0, 0, 0, 0, 0, 1);

    // Conditional jump, both polarities
    step(3, 20, 0, 1, 0, 0, 0, 1);
    step(3, 20, 0, 1, 1, 0, 0, 1);
    step(3, 20, 0, 0, 1, 0, 0, 1);

    // Wait handshake
    step(1, 5, 0, 0, 0, 0, 0, 1);
    repeat (4) step(4, 0, 0, 0, 0, 0, 0, 1);
    step(4, 0, 0, 0, 0, 1, 0, 1);

    // Held wait: traps on the limit when the timeout is built, holds otherwise
    step(1, 7, 0, 0, 0, 0, 0, 1);
    repeat (WAIT_LIMIT + 5) step(4, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);

    // Completion exactly on the limit cycle
    step(1, 8, 0, 0, 0, 0, 0, 1);
    repeat (WAIT_LIMIT - 1) step(4, 0, 0, 0, 0, 0, 0, 1);
    step(4, 0, 0, 0, 0, 1, 0, 1);

    // Call / return
    step(1, 10, 0, 0, 0, 0, 0, 1);
    step(5, 30, 0, 0, 0, 0, 0, 1);
    step(5, 40, 0, 0, 0, 0, 0, 1);
    step(6, 0, 0, 0, 0, 0, 0, 1);
    step(6, 0, 0, 0, 0, 0, 0, 1);

    // Overflow, clear racing a new error, underflow, reset mid-stack
    step(1, 10, 0, 0, 0, 0, 0, 1);
    step(5, 30, 0, 0, 0, 0, 0, 1);
    step(5, 40, 0, 0, 0, 0, 0, 1);
    step(5, 50, 0, 0, 0, 0, 0, 1);
    step(5, 50, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    step(6, 0, 0, 0, 0, 0, 0, 1);
    step(6, 0, 0, 0, 0, 0, 0, 1);
    step(6, 0, 0, 0, 0, 0, 0, 1);
    step(5, 12, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);

    // Randomized traffic with occasional long waits and resets
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 50) begin
        int len;
        len = $urandom_range(WAIT_LIMIT - 3, WAIT_LIMIT + 3);
        for (int k = 0; k < len; k++) step(4, 0, 0, 0, 0, 0, 0, 1);
      end else begin
        step($urandom_range(0, 7), $urandom_range(0, NSTATES - 1),
             $urandom_range(0, NSTATES - 1), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 199) != 0));
      end
    end

    step(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (2) @(posedge Clk);
    #3;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
